// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_AW = 32;
    localparam int unsigned MEM_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port.
// master: the arbiter's view. slave: pipeline + memory (environment) view.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic [DW-1:0] if_rdata;
    logic          if_rvalid;
    logic          if_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;
    logic          d_stall;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;

    modport master (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_gnt, mem_rdata, mem_rvalid,
        output if_rdata, if_rvalid, if_stall,
        output d_rdata, d_rvalid, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata,
        output mem_gnt, mem_rdata, mem_rvalid,
        input  if_rdata, if_rvalid, if_stall,
        input  d_rdata, d_rvalid, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant decision between fetch and data requesters.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  logic   starve_hit,
    output owner_t owner
);

    // Data wins by default; a fetch that has waited through enough data grants wins instead.
    always_comb begin
        owner = OWN_NONE;
        if (if_req && starve_hit) begin
            owner = OWN_IF;
        end else if (d_req) begin
            owner = OWN_D;
        end else if (if_req) begin
            owner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One outstanding transaction; killed fetch responses are consumed silently.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = MEM_AW,
    parameter int unsigned DW         = MEM_DW,
    parameter int unsigned STARVE_MAX = 4
)(
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.master bus
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    state_t        state_q, state_d;
    owner_t        owner_q, pick;
    mem_cmd_t      cmd_q;
    logic          mem_req_q;
    logic          drop_q;
    logic [CW-1:0] starve_cnt;
    logic          if_rvalid_q, d_rvalid_q;
    logic [DW-1:0] if_rdata_q, d_rdata_q;

    logic starve_hit, flush_hit;
    logic load_cmd, req_clr, drop_set, drop_clr, pulse_if, pulse_d;

    assign starve_hit = (starve_cnt == CW'(STARVE_MAX));
    assign flush_hit  = bus.if_flush && (owner_q == OWN_IF);

    mem_arb_pick u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .starve_hit (starve_hit),
        .owner      (pick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a flush before grant aborts; a flush at or after grant rides through WAIT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick != OWN_NONE) state_d = ISSUE;
            ISSUE: begin
                if (bus.mem_gnt) begin
                    state_d = WAIT;
                end else if (flush_hit) begin
                    state_d = IDLE;
                end
            end
            WAIT:    if (bus.mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/control strobes for the datapath registers.
    always_comb begin
        load_cmd = 1'b0;
        req_clr  = 1'b0;
        drop_set = 1'b0;
        drop_clr = 1'b0;
        pulse_if = 1'b0;
        pulse_d  = 1'b0;
        unique case (state_q)
            IDLE:  load_cmd = (pick != OWN_NONE);
            ISSUE: begin
                req_clr  = bus.mem_gnt || flush_hit;
                drop_set = bus.mem_gnt && flush_hit;
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    drop_clr = 1'b1;
                    pulse_if = (owner_q == OWN_IF) && !drop_q && !flush_hit;
                    pulse_d  = (owner_q == OWN_D);
                end else begin
                    drop_set = flush_hit;
                end
            end
            default: ;
        endcase
    end

    // Command register, owner and drop flag for the transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q   <= OWN_NONE;
            cmd_q     <= '0;
            mem_req_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            if (load_cmd) begin
                owner_q     <= pick;
                cmd_q.we    <= (pick == OWN_D) && bus.d_we;
                cmd_q.addr  <= (pick == OWN_D) ? bus.d_addr : bus.if_addr;
                cmd_q.wdata <= (pick == OWN_D) ? bus.d_wdata : '0;
                mem_req_q   <= 1'b1;
            end else if (req_clr) begin
                mem_req_q <= 1'b0;
            end
            if (drop_set) begin
                drop_q <= 1'b1;
            end else if (drop_clr) begin
                drop_q <= 1'b0;
            end
        end
    end

    // Response pulses and captured read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= pulse_if;
            d_rvalid_q  <= pulse_d;
            if (pulse_if) if_rdata_q <= bus.mem_rdata;
            if (pulse_d)  d_rdata_q  <= bus.mem_rdata;
        end
    end

    // Count data grants that overtook a waiting fetch.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.if_req) begin
            starve_cnt <= '0;
        end else if (load_cmd && pick == OWN_IF) begin
            starve_cnt <= '0;
        end else if (load_cmd && pick == OWN_D && !starve_hit) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_addr  = cmd_q.addr[AW-1:0];
    assign bus.mem_wdata = cmd_q.wdata[DW-1:0];
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_stall  = bus.if_req & ~if_rvalid_q;
    assign bus.d_stall   = bus.d_req & ~d_rvalid_q;

    // A data requester must hold d_req until its response.
    a_d_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != IDLE && owner_q == OWN_D) |-> bus.d_req);

    // A fetch may only give up its request through a flush.
    a_if_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != IDLE && owner_q == OWN_IF && !drop_q) |-> (bus.if_req || bus.if_flush));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reactive memory model, per-requester
// expected-response queues, and cycle-exact directed checks.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model state and knobs
    int          gnt_delay = 0;
    int          rsp_lat   = 1;
    bit          stray_rv  = 1'b0;
    int          gcnt      = 0;
    int          lcnt      = 0;
    bit          pend      = 1'b0;
    logic [31:0] rsp       = '0;
    logic [31:0] mem_img [logic [31:0]];
    logic [32:0] gnt_log [$];

    logic [31:0] if_exp_q [$];
    logic [31:0] d_exp_q  [$];
    int          if_pulses = 0;
    int          d_pulses  = 0;
    int          d_base, d_at_if;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: grant after gnt_delay cycles of mem_req, respond rsp_lat cycles after grant
    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
            if (!rst_n) begin
                pend = 1'b0;
                gcnt = 0;
            end else if (stray_rv) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hBAD0_BAD0;
                stray_rv       = 1'b0;
            end else if (pend) begin
                if (lcnt <= 1) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rsp;
                    pend           = 1'b0;
                end else begin
                    lcnt--;
                end
            end else if (bus.mem_req) begin
                if (gcnt >= gnt_delay) begin
                    bus.mem_gnt = 1'b1;
                    gcnt = 0;
                    pend = 1'b1;
                    lcnt = rsp_lat;
                    gnt_log.push_back({bus.mem_we, bus.mem_addr});
                    if (bus.mem_we) begin
                        mem_img[bus.mem_addr] = bus.mem_wdata;
                        rsp = '0;
                    end else begin
                        rsp = rd_val(bus.mem_addr);
                    end
                end else begin
                    gcnt++;
                end
            end else begin
                gcnt = 0;
            end
        end
    end

    // Scoreboard: every response pulse must match the oldest expectation of its requester
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.if_rvalid) begin
                if_pulses++;
                if (if_exp_q.size() == 0) check("if_unexpected_pulse", 32'(bus.if_rvalid), 32'd0);
                else check("if_rdata", bus.if_rdata, if_exp_q.pop_front());
            end
            if (bus.d_rvalid) begin
                d_pulses++;
                if (d_exp_q.size() == 0) check("d_unexpected_pulse", 32'(bus.d_rvalid), 32'd0);
                else check("d_rdata", bus.d_rdata, d_exp_q.pop_front());
            end
        end
    end

    task automatic do_fetch(input logic [31:0] addr);
        int n = 0;
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
        if_exp_q.push_back(rd_val(addr));
        do begin
            @(negedge clk);
            n++;
        end while (!bus.if_rvalid && n < 300);
        check("if_timeout", 32'(bus.if_rvalid), 32'd1);
        bus.if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_req   = 1'b1;
        d_exp_q.push_back(we ? 32'd0 : rd_val(addr));
        do begin
            @(negedge clk);
            n++;
        end while (!bus.d_rvalid && n < 300);
        check("d_timeout", 32'(bus.d_rvalid), 32'd1);
        bus.d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_flush = 1'b0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        rst_n        = 1'b0;
        mem_img[32'h10] = 32'h0050_0093;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req",   32'(bus.mem_req),   32'd0);
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_mem_addr",  bus.mem_addr,       32'd0);
        check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check("rst_d_rvalid",  32'(bus.d_rvalid),  32'd0);
        check("rst_state",     32'(dut.state_q),   32'(IDLE));
        check("rst_starve",    32'(dut.starve_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch only, zero-wait memory: mem_req at +1, pulse at +3
        gnt_delay = 0;
        rsp_lat   = 1;
        bus.if_addr = 32'h10;
        bus.if_req  = 1'b1;
        if_exp_q.push_back(32'h0050_0093);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            check("t2_mem_req",   32'(bus.mem_req),   32'(c == 1));
            check("t2_if_stall",  32'(bus.if_stall),  32'(c < 3));
            check("t2_if_rvalid", 32'(bus.if_rvalid), 32'(c == 3));
            if (c == 1) begin
                check("t2_mem_addr", bus.mem_addr,     32'h10);
                check("t2_mem_we",   32'(bus.mem_we),  32'd0);
            end
        end
        bus.if_req = 1'b0;

        // Simultaneous store and fetch: store granted first
        @(negedge clk);
        gnt_log.delete();
        fork
            do_data(1'b1, 32'h100, 32'hDEAD_BEEF);
            do_fetch(32'h40);
        join
        check("t3_gnt_count", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() >= 2) begin
            check("t3_first_we",    32'(gnt_log[0][32]), 32'd1);
            check("t3_first_addr",  gnt_log[0][31:0],    32'h100);
            check("t3_second_we",   32'(gnt_log[1][32]), 32'd0);
            check("t3_second_addr", gnt_log[1][31:0],    32'h40);
        end
        do_data(1'b0, 32'h100, 32'd0);

        // Starvation: six back-to-back loads against a waiting fetch
        @(negedge clk);
        d_base = d_pulses;
        fork
            begin
                for (int i = 0; i < 6; i++) do_data(1'b0, 32'h300 + 32'(4 * i), 32'd0);
            end
            begin
                do_fetch(32'h80);
                d_at_if = d_pulses - d_base;
                check("t4_starve_cnt", 32'(dut.starve_cnt), 32'd0);
            end
        join
        check("t4_data_before_fetch", 32'(d_at_if), 32'd4);

        // Flush while the fetch waits for its response
        rsp_lat = 3;
        @(negedge clk);
        bus.if_addr = 32'h20;
        bus.if_req  = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_in_wait", 32'(dut.state_q), 32'(WAIT));
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
        @(negedge clk);
        bus.if_flush = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t5_no_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        end
        check("t5_drop_clear", 32'(dut.drop_q), 32'd0);
        do_fetch(32'h24);

        // Flush before grant aborts the request
        gnt_delay = 3;
        rsp_lat   = 1;
        @(negedge clk);
        bus.if_addr = 32'h28;
        bus.if_req  = 1'b1;
        @(negedge clk);
        check("t5b_mem_req", 32'(bus.mem_req), 32'd1);
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
        @(negedge clk);
        bus.if_flush = 1'b0;
        check("t5b_mem_req_drop", 32'(bus.mem_req), 32'd0);
        check("t5b_state",        32'(dut.state_q), 32'(IDLE));
        repeat (3) begin
            @(negedge clk);
            check("t5b_no_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        end

        // Back-pressure on a load, with a stray flush that must not touch it
        gnt_delay = 3;
        rsp_lat   = 4;
        @(negedge clk);
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h200;
        bus.d_req  = 1'b1;
        d_exp_q.push_back(rd_val(32'h200));
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            bus.if_flush = (c == 6);
            check("t6_mem_req", 32'(bus.mem_req), 32'(c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) begin
                check("t6_mem_addr", bus.mem_addr,    32'h200);
                check("t6_mem_we",   32'(bus.mem_we), 32'd0);
            end
            check("t6_d_stall",  32'(bus.d_stall),  32'(c < 9));
            check("t6_d_rvalid", 32'(bus.d_rvalid), 32'(c == 9));
            if (c == 9) bus.d_req = 1'b0;
        end
        bus.if_flush = 1'b0;

        // Reset mid-WAIT, then a stray memory response
        gnt_delay = 0;
        rsp_lat   = 6;
        @(negedge clk);
        bus.if_addr = 32'h30;
        bus.if_req  = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_in_wait", 32'(dut.state_q), 32'(WAIT));
        rst_n      = 1'b0;
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_mem_req",   32'(bus.mem_req),   32'd0);
        check("t1_mem_we",    32'(bus.mem_we),    32'd0);
        check("t1_mem_addr",  bus.mem_addr,       32'd0);
        check("t1_mem_wdata", bus.mem_wdata,      32'd0);
        check("t1_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check("t1_d_rvalid",  32'(bus.d_rvalid),  32'd0);
        check("t1_if_rdata",  bus.if_rdata,       32'd0);
        check("t1_d_rdata",   bus.d_rdata,        32'd0);
        check("t1_state",     32'(dut.state_q),   32'(IDLE));
        check("t1_owner",     32'(dut.owner_q),   32'(OWN_NONE));
        rst_n    = 1'b1;
        stray_rv = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t1_stray_if", 32'(bus.if_rvalid), 32'd0);
            check("t1_stray_d",  32'(bus.d_rvalid),  32'd0);
        end

        check("sb_if_empty", 32'(if_exp_q.size()), 32'd0);
        check("sb_d_empty",  32'(d_exp_q.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
